gf8_systolic_mult: RTL

Pipelined GF(2^8) multiplier built as an 8-row MSB-first systolic array: one row per bit of operand b, one register stage per row. It accepts a new operand pair every enabled cycle and produces the field product 8 enabled cycles later. It is the compute stage of the finite-field multiplier datapath, and its product output feeds the downstream 8-bit register/delay stages.

---
 rtl/gf8_pkg.sv | 27 ++
 rtl/gf8_systolic_mult_if.sv | 22 ++
 rtl/gf8_mac_row.sv | 48 ++++
 rtl/gf8_systolic_mult.sv | 50 +++++
 4 files changed

// File: rtl/gf8_pkg.sv
// GF(2^8) shared types, field constants and arithmetic helpers.
// Index 1 of a field element is the x^7 coefficient, index 8 is x^0.
package gf8_pkg;

  typedef logic [1:8] gf8_elem_t;

  localparam gf8_elem_t GF8_POLY_AES = 8'h1B;

  // Multiply by x: shift toward bit 1, reduce if x^7 overflowed.
  function automatic gf8_elem_t gf8_xtime(input gf8_elem_t elem, input gf8_elem_t poly);
    gf8_elem_t shifted;
    shifted = {elem[2:8], 1'b0};
    return elem[1] ? (shifted ^ poly) : shifted;
  endfunction

  // MSB-first reference product, the same recurrence the array unrolls.
  function automatic gf8_elem_t gf8_mul(input gf8_elem_t a, input gf8_elem_t b,
                                        input gf8_elem_t poly);
    gf8_elem_t r;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      r = gf8_xtime(r, poly) ^ (b[k] ? a : '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf8_systolic_mult_if.sv
// Operand/product bus of the systolic GF(2^8) multiplier.
interface gf8_systolic_mult_if;
  import gf8_pkg::*;

  logic      en;
  logic      in_valid;
  gf8_elem_t a;
  gf8_elem_t b;
  logic      out_valid;
  gf8_elem_t p;

  modport master (
    output en, in_valid, a, b,
    input  out_valid, p
  );

  modport slave (
    input  en, in_valid, a, b,
    output out_valid, p
  );

endinterface

// File: rtl/gf8_mac_row.sv
// One row of the systolic multiplier: r_out = xtime(r_in) ^ (b[ROW] ? a : 0),
// registered together with a, the still-unconsumed b bits and valid.
module gf8_mac_row
  import gf8_pkg::*;
#(
  parameter int        ROW  = 1,
  parameter gf8_elem_t POLY = GF8_POLY_AES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      valid_in,
  input  gf8_elem_t r_in,
  input  gf8_elem_t a_in,
  input  gf8_elem_t b_in,
  output logic      valid_out,
  output gf8_elem_t r_out,
  output gf8_elem_t a_out,
  output gf8_elem_t b_out
);

  // Bits ROW+1..8 are still needed downstream; the rest are forced to zero
  // so their flops are constant and disappear in synthesis.
  localparam gf8_elem_t KEEP_MASK = gf8_elem_t'(8'hFF >> ROW);

  gf8_elem_t r_next;

  // Combinational multiply-accumulate step for this row's b bit.
  always_comb begin
    r_next = gf8_xtime(r_in, POLY) ^ (b_in[ROW] ? a_in : '0);
  end

  // Row pipeline register: cleared by reset, frozen while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      r_out     <= '0;
      a_out     <= '0;
      b_out     <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      r_out     <= r_next;
      a_out     <= a_in;
      b_out     <= b_in & KEEP_MASK;
    end
  end

endmodule

// File: rtl/gf8_systolic_mult.sv
// Eight-row MSB-first systolic GF(2^8) multiplier, 8 enabled cycles latency,
// one product per enabled cycle, no backpressure.
module gf8_systolic_mult
  import gf8_pkg::*;
#(
  parameter gf8_elem_t POLY = GF8_POLY_AES
) (
  input logic                clk,
  input logic                rst,
  gf8_systolic_mult_if.slave bus
);

  logic      valid_pipe [0:8];
  gf8_elem_t r_pipe     [0:8];
  gf8_elem_t a_pipe     [0:8];
  gf8_elem_t b_pipe     [0:8];
  logic      unused_tail;

  // Stage 0 is the raw input; the accumulator starts from zero.
  assign valid_pipe[0] = bus.in_valid;
  assign r_pipe[0]     = '0;
  assign a_pipe[0]     = bus.a;
  assign b_pipe[0]     = bus.b;

  for (genvar k = 1; k <= 8; k++) begin : g_row
    gf8_mac_row #(
      .ROW  (k),
      .POLY (POLY)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .valid_in  (valid_pipe[k-1]),
      .r_in      (r_pipe[k-1]),
      .a_in      (a_pipe[k-1]),
      .b_in      (b_pipe[k-1]),
      .valid_out (valid_pipe[k]),
      .r_out     (r_pipe[k]),
      .a_out     (a_pipe[k]),
      .b_out     (b_pipe[k])
    );
  end

  // The last row's operand copies have no consumer.
  assign unused_tail = ^{a_pipe[8], b_pipe[8]};

  assign bus.p         = r_pipe[8];
  assign bus.out_valid = valid_pipe[8];

endmodule
